// File: rtl/msk_ref_pipe.sv
// msk_ref_pipe -- two-stage pipelined refresh of a Boolean masking.
//
// Each of the N masked bits arrives as d shares. A fresh zero-sum mask,
// built from the rnd word, is XORed onto the shares. The XOR of the shares,
// which is the unmasked value, is unchanged, but the shares themselves are
// re-randomised.
//   Stage 1 registers the input sharing and the mask separately. The two
//   are never combined before a register boundary, so no glitch can
//   recombine input shares with their mask.
//   Stage 2 registers data1 ^ mask1 and drives out_data.
//
// Ports
//   clk        clock; all state changes on the rising edge
//   rst_n      synchronous active-low reset
//   in_data    N*d input shares; share i of bit j is at index j*d+i
//   in_valid   in_data valid
//   in_ready   block can take in_data this cycle
//   rnd        N*R fresh random bits; bit k for masked bit j is at j*R+k
//   rnd_valid  rnd valid
//   rnd_ready  rnd is taken this cycle if rnd_valid is also high
//   out_data   refreshed shares, same layout as in_data
//   out_valid  out_data valid
//   out_ready  downstream takes out_data
//   xfer_cnt   number of accepted inputs, modulo 2^CW
module msk_ref_pipe #(
  parameter int d    = 2,
  parameter int N    = 1,
  parameter int MODE = 0,
  parameter int CW   = 16,
  localparam int R     = (d == 2) ? 1 : ((MODE == 0) ? d : d - 1),
  localparam int RND_W = N * R
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N*d-1:0]   in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [RND_W-1:0] rnd,
  input  logic             rnd_valid,
  output logic             rnd_ready,
  output logic [N*d-1:0]   out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CW-1:0]    xfer_cnt
);

  logic [N*d-1:0] mask_next;
  logic [N*d-1:0] data1_reg;
  logic [N*d-1:0] mask1_reg;
  logic           v1_reg;
  logic [N*d-1:0] out_data_reg;
  logic           v2_reg;
  logic [CW-1:0]  xfer_cnt_reg;

  logic load1;
  logic load2;
  logic accept;

  // Per-bit zero-sum mask generation.
  genvar gi, gk;
  generate
    for (gi = 0; gi < N; gi++) begin : g_bit
      logic [R-1:0] r;
      logic [d-1:0] m;
      assign r = rnd[gi*R +: R];

      if (d == 2) begin : g_two
        // Both shares receive the same random bit.
        assign m = {2{r[0]}};
      end else if (MODE == 0) begin : g_ring
        // Ring refresh: each random bit is used by two neighbouring shares,
        // so every r_k appears exactly twice and the total cancels.
        for (gk = 0; gk < d; gk++) begin : g_sh
          assign m[gk] = r[gk] ^ r[(gk + d - 1) % d];
        end
      end else begin : g_sum
        // Sum refresh: the last share absorbs the XOR of all the others.
        assign m[d-2:0] = r;
        assign m[d-1]   = ^r;
      end

      assign mask_next[gi*d +: d] = m;
    end
  endgenerate

  // Handshake. Stage 1 can load exactly when a new input can be taken, so
  // in_ready and load1 are the same term.
  assign load2     = !v2_reg || out_ready;
  assign load1     = !v1_reg || load2;
  assign in_ready  = !v1_reg || !v2_reg || out_ready;
  assign rnd_ready = in_valid && in_ready;
  assign accept    = in_valid && rnd_valid && in_ready;

  // Stage 1. If in_valid is high but no randomness is present, a bubble
  // (v1 = 0) is loaded and the source keeps its data for a later cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1_reg    <= 1'b0;
      data1_reg <= '0;
      mask1_reg <= '0;
    end else if (load1) begin
      v1_reg    <= accept;
      data1_reg <= in_data;
      mask1_reg <= mask_next;
    end
  end

  // Stage 2. Holds its contents while out_valid is high and out_ready is low.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v2_reg       <= 1'b0;
      out_data_reg <= '0;
    end else if (load2) begin
      v2_reg       <= v1_reg;
      out_data_reg <= data1_reg ^ mask1_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      xfer_cnt_reg <= '0;
    end else if (accept) begin
      xfer_cnt_reg <= xfer_cnt_reg + {{(CW-1){1'b0}}, 1'b1};
    end
  end

  assign out_data  = out_data_reg;
  assign out_valid = v2_reg;
  assign xfer_cnt  = xfer_cnt_reg;

endmodule

// File: tb/tb_msk_ref_pipe.sv
// Testbench for msk_ref_pipe.
// The main instance uses d=4, N=2, MODE=1, CW=4. It runs a scoreboard that
// covers streaming, backpressure, missing randomness, counter wrap and reset.
// Two small instances (d=2 and d=3 ring mode) run directed mask vectors.
module tb_msk_ref_pipe;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Main DUT: d=4, N=2, MODE=1 (R=3, RND_W=6), CW=4.
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [5:0] rnd;
  logic       rnd_valid;
  logic       rnd_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] xfer_cnt;

  msk_ref_pipe #(.d(4), .N(2), .MODE(1), .CW(4)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .rnd(rnd), .rnd_valid(rnd_valid), .rnd_ready(rnd_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .xfer_cnt(xfer_cnt)
  );

  // Small DUT: d=2, N=1.
  logic [1:0]  a_in_data, a_out_data;
  logic        a_in_valid, a_in_ready, a_rnd_valid, a_rnd_ready, a_out_valid;
  logic [0:0]  a_rnd;
  logic [15:0] a_xfer_cnt;

  msk_ref_pipe #(.d(2), .N(1), .MODE(0), .CW(16)) u_d2 (
    .clk(clk), .rst_n(rst_n),
    .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .rnd(a_rnd), .rnd_valid(a_rnd_valid), .rnd_ready(a_rnd_ready),
    .out_data(a_out_data), .out_valid(a_out_valid), .out_ready(1'b1),
    .xfer_cnt(a_xfer_cnt)
  );

  // Small DUT: d=3, N=1, ring mode (R=3).
  logic [2:0]  b_in_data, b_out_data, b_rnd;
  logic        b_in_valid, b_in_ready, b_rnd_valid, b_rnd_ready, b_out_valid;
  logic [15:0] b_xfer_cnt;

  msk_ref_pipe #(.d(3), .N(1), .MODE(0), .CW(16)) u_d3 (
    .clk(clk), .rst_n(rst_n),
    .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .rnd(b_rnd), .rnd_valid(b_rnd_valid), .rnd_ready(b_rnd_ready),
    .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(1'b1),
    .xfer_cnt(b_xfer_cnt)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] sb_q[$];
  int         occ;
  logic [3:0] cnt_model;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference for sum refresh with d=4: m0..m2 = r0..r2, m3 = r0^r1^r2.
  function automatic logic [7:0] exp_main(input logic [7:0] din, input logic [5:0] r);
    logic [7:0] m;
    logic [2:0] rr;
    for (int j = 0; j < 2; j++) begin
      rr = r[j*3 +: 3];
      m[j*4 +: 4] = {rr[0] ^ rr[1] ^ rr[2], rr};
    end
    return din ^ m;
  endfunction

  // Reference for ring refresh with d=3: m_i = r_i ^ r_((i+2) mod 3).
  function automatic logic [2:0] exp_ring3(input logic [2:0] din, input logic [2:0] r);
    logic [2:0] m;
    m[0] = r[0] ^ r[2];
    m[1] = r[1] ^ r[0];
    m[2] = r[2] ^ r[1];
    return din ^ m;
  endfunction

  // One clock cycle on the main DUT. Inputs are driven on the falling edge.
  // Outputs are sampled 1 time unit later. The transfer happens on the next
  // rising edge.
  task automatic step(input logic iv, input logic rv, input logic [7:0] id,
                      input logic [5:0] rn, input logic ordy,
                      output logic acc, output logic ov);
    logic exp_rdy;
    @(negedge clk);
    in_valid = iv; rnd_valid = rv; in_data = id; rnd = rn; out_ready = ordy;
    #1;
    exp_rdy = (occ < 2) || ordy;
    chk("in_ready", in_ready, exp_rdy);
    chk("rnd_ready", rnd_ready, iv && exp_rdy);
    ov  = out_valid;
    acc = iv && rv && in_ready;
    if (out_valid && ordy) begin
      if (sb_q.size() == 0) chk("spurious_out", 1, 0);
      else chk("out_data", out_data, sb_q.pop_front());
      occ--;
    end
    if (acc) begin
      sb_q.push_back(exp_main(id, rn));
      occ++;
      cnt_model++;
    end
    @(posedge clk);
    #1;
    chk("xfer_cnt", xfer_cnt, cnt_model);
  endtask

  task automatic drain();
    logic a, v;
    for (int i = 0; i < 20 && sb_q.size() != 0; i++) step(0, 0, 8'h00, 6'h00, 1, a, v);
    chk("drain_left", sb_q.size(), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0; in_valid = 1; rnd_valid = 1; out_ready = 0;
    @(posedge clk); #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_xfer_cnt", xfer_cnt, 0);
    @(negedge clk);
    rst_n = 1; in_valid = 0; rnd_valid = 0;
    sb_q.delete(); occ = 0; cnt_model = 0;
    #1;
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_out_valid", out_valid, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic acc, ov, a2, ov2;
    logic [7:0] held;
    logic       have_held;
    int         n_acc, cyc;
    logic [1:0] a_exp;
    logic [2:0] b_exp;

    rst_n = 0; in_valid = 0; rnd_valid = 0; in_data = 0; rnd = 0; out_ready = 0;
    a_in_data = 0; a_in_valid = 0; a_rnd_valid = 0; a_rnd = 0;
    b_in_data = 0; b_in_valid = 0; b_rnd_valid = 0; b_rnd = 0;
    occ = 0; cnt_model = 0;
    repeat (2) @(posedge clk);
    do_reset();
    chk("rst_xfer_a", a_xfer_cnt, 0);
    chk("rst_out_a", a_out_valid, 0);

    // Small DUTs: the first vector is fixed, the rest are random.
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 0) begin
        a_in_data = 2'b01; a_rnd = 1'b1; b_in_data = 3'b000; b_rnd = 3'b001;
      end else begin
        a_in_data = 2'($urandom); a_rnd = 1'($urandom);
        b_in_data = 3'($urandom); b_rnd = 3'($urandom);
      end
      a_exp = a_in_data ^ {a_rnd[0], a_rnd[0]};
      b_exp = exp_ring3(b_in_data, b_rnd);
      a_in_valid = 1; a_rnd_valid = 1; b_in_valid = 1; b_rnd_valid = 1;
      @(negedge clk);
      a_in_valid = 0; a_rnd_valid = 0; b_in_valid = 0; b_rnd_valid = 0;
      @(negedge clk);
      chk("d2_out_valid", a_out_valid, 1);
      chk("d2_out_data", a_out_data, a_exp);
      chk("d2_xfer_cnt", a_xfer_cnt, k + 1);
      chk("d3_out_valid", b_out_valid, 1);
      chk("d3_out_data", b_out_data, b_exp);
      chk("d3_share_xor", ^b_out_data, ^b_in_data);
      if (k == 0) begin
        chk("d2_fixed", a_out_data, 2'b10);
        chk("d3_fixed", b_out_data, 3'b011);
      end
    end

    // Latency: accept in cycle t, output valid in t+2, not in t+1.
    step(1, 1, 8'h5a, 6'h2d, 1, acc, ov);
    chk("lat_accept", acc, 1);
    step(0, 0, 8'h00, 6'h00, 1, acc, ov);
    chk("lat_t1_valid", ov, 0);
    step(0, 0, 8'h00, 6'h00, 1, acc, ov);
    chk("lat_t2_valid", ov, 1);

    // Back-to-back throughput.
    for (int i = 0; i < 6; i++) begin
      step(1, 1, 8'($urandom), 6'($urandom), 1, acc, ov);
      chk("thru_accept", acc, 1);
    end
    drain();

    // in_valid without rnd_valid: rnd_ready high, no accept.
    step(1, 0, 8'hff, 6'h3f, 1, acc, ov);
    chk("no_rnd_accept", acc, 0);
    drain();

    // Backpressure for 5 cycles with continuous input.
    do_reset();
    n_acc = 0; have_held = 0; held = 0;
    for (int i = 0; i < 5; i++) begin
      step(1, 1, 8'($urandom), 6'($urandom), 0, acc, ov);
      if (acc) n_acc++;
      if (out_valid) begin
        if (have_held) chk("bp_hold", out_data, held);
        else begin held = out_data; have_held = 1; end
      end
    end
    chk("bp_accepts", n_acc, 2);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_out_valid", out_valid, 1);
    drain();

    // Counter wrap: 17 accepts with CW=4 leave the counter at 1.
    do_reset();
    for (int i = 0; i < 17; i++) step(1, 1, 8'($urandom), 6'($urandom), 1, acc, ov);
    drain();
    chk("wrap_xfer_cnt", xfer_cnt, 1);

    // Reset with two items in flight: they must never appear.
    do_reset();
    step(1, 1, 8'h11, 6'h01, 0, acc, ov);
    step(1, 1, 8'h22, 6'h02, 0, acc, ov);
    chk("inflight_occ", occ, 2);
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 8'h00, 6'h00, 1, acc, ov);
      chk("flushed_out_valid", ov, 0);
    end

    // Random stream of 1000 items with random backpressure and gaps.
    n_acc = 0; cyc = 0;
    while (n_acc < 1000 && cyc < 8000) begin
      step(($urandom % 4) != 0, ($urandom % 4) != 0, 8'($urandom), 6'($urandom),
           1'($urandom), a2, ov2);
      if (a2) n_acc++;
      cyc++;
    end
    chk("stream_count", n_acc, 1000);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
